// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter
//   Shares one single-port character RAM between the display scan, a host
//   port and the clear-screen sequencer. Priority per cycle:
//   display > clear > host FIFO head. Read data is steered back to the
//   requester by a registered owner tag.
// Ports:
//   clk, clr_n                     clock, async active-low reset
//   disp_req/addr, disp_valid/data display reads, fixed 1-cycle latency
//   host_valid/ready/we/addr/wdata host requests into a 2-entry FIFO
//   host_rvalid/rdata              host read responses
//   clr_screen, clearing, clear_done  clear sequencer control/status
//   ram_en/we/addr/wdata, ram_rdata   shared RAM port (1-cycle read latency)
module text_ram_arbiter #(
  parameter int                DEPTH      = 2400,
  parameter int                ADDR_W     = 12,
  parameter int                DATA_W     = 6,
  parameter logic [DATA_W-1:0] CLEAR_CODE = 6'h3F
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              clr_screen,
  output logic              clearing,
  output logic              clear_done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } hreq_t;

  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_HOST = 2'd2} tag_e;
  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_e;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  state_e            state;
  logic [ADDR_W-1:0] clr_cnt;
  tag_e              tag_q;
  hreq_t             ent0, ent1, hin;
  logic [1:0]        cnt;
  logic              run_q;
  logic [DATA_W-1:0] disp_last, host_last;

  logic disp_in, head_in, full, enq, host_issue, host_go, head_rd;

  assign hin        = {host_we, host_addr, host_wdata};
  assign disp_in    = {1'b0, disp_addr} < DEPTH_X;
  assign head_in    = {1'b0, ent0.addr} < DEPTH_X;
  assign full       = (cnt == 2'd2);
  // run_q keeps host_ready low while reset is asserted.
  assign host_ready = run_q && !full && !clearing;
  assign enq        = host_valid && host_ready;
  // Out-of-range heads still dequeue here; they just never touch the RAM.
  assign host_issue = (cnt != 2'd0) && !disp_req && !clearing;
  assign host_go    = host_issue && head_in;
  assign head_rd    = host_issue && !ent0.we;

  // RAM port: combinational from this cycle's winner.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (disp_req) begin
      if (disp_in) begin
        ram_en   = 1'b1;
        ram_addr = disp_addr;
      end
    end else if (clearing) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = clr_cnt;
      ram_wdata = CLEAR_CODE;
    end else if (host_go) begin
      ram_en    = 1'b1;
      ram_we    = ent0.we;
      ram_addr  = ent0.addr;
      ram_wdata = ent0.we ? ent0.wdata : '0;
    end
  end

  // Clear sequencer; the counter only advances on cycles display leaves free.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= S_IDLE;
      clr_cnt    <= '0;
      clearing   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        S_IDLE: if (clr_screen) begin
          state    <= S_CLEAR;
          clr_cnt  <= '0;
          clearing <= 1'b1;
        end
        S_CLEAR: if (!disp_req) begin
          if (clr_cnt == LAST) begin
            state      <= S_IDLE;
            clr_cnt    <= '0;
            clearing   <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // 2-entry host FIFO; ent0 is always the head.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt   <= '0;
      ent0  <= '0;
      ent1  <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case ({enq, host_issue})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= hin;
          else             ent1 <= hin;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) ent0 <= hin;
          else begin
            ent0 <= ent1;
            ent1 <= hin;
          end
        end
        default: ;
      endcase
    end
  end

  // Response steering. Owner gets ram_rdata live; the other port shows its
  // held value. Out-of-range reads load a zero into the hold register so
  // the response cycle reads back 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tag_q       <= TAG_NONE;
      disp_valid  <= 1'b0;
      host_rvalid <= 1'b0;
      disp_last   <= '0;
      host_last   <= '0;
    end else begin
      disp_valid  <= disp_req;
      host_rvalid <= head_rd;
      if (disp_req)               tag_q <= disp_in ? TAG_DISP : TAG_NONE;
      else if (host_go && !ent0.we) tag_q <= TAG_HOST;
      else                        tag_q <= TAG_NONE;
      if (tag_q == TAG_DISP)  disp_last <= ram_rdata;
      if (disp_req && !disp_in) disp_last <= '0;
      if (tag_q == TAG_HOST)  host_last <= ram_rdata;
      if (head_rd && !head_in) host_last <= '0;
    end
  end

  assign disp_data  = (tag_q == TAG_DISP) ? ram_rdata : disp_last;
  assign host_rdata = (tag_q == TAG_HOST) ? ram_rdata : host_last;

endmodule

// File: tb/tb_text_ram_arbiter.sv
module tb_text_ram_arbiter;
  localparam int DEPTH = 2400;
  localparam int AW = 12;
  localparam int DW = 6;

  logic          clk = 1'b0, clr_n = 1'b0;
  logic          disp_req, disp_valid, host_valid, host_ready, host_we, host_rvalid;
  logic          clr_screen, clearing, clear_done, ram_en, ram_we;
  logic [AW-1:0] disp_addr, host_addr, ram_addr;
  logic [DW-1:0] disp_data, host_wdata, host_rdata, ram_wdata, ram_rdata;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int checks = 0, errors = 0;

  text_ram_arbiter dut (
    .clk(clk), .clr_n(clr_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid), .disp_data(disp_data),
    .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .clr_screen(clr_screen), .clearing(clearing), .clear_done(clear_done),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic to_drive();
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    disp_req = 1'b0; disp_addr = '0; host_valid = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; clr_screen = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    clr_n = 1'b0;
    #12;
    checks++;
    if ({disp_valid, disp_data, host_ready, host_rvalid, host_rdata, clearing, clear_done,
         ram_en, ram_we, ram_addr, ram_wdata} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got dv=%b dd=%0d hr=%b hrv=%b hrd=%0d cl=%b cd=%b en=%b we=%b, want all 0",
               disp_valid, disp_data, host_ready, host_rvalid, host_rdata, clearing, clear_done, ram_en, ram_we);
    end
    @(negedge clk); clr_n = 1'b1;
    to_drive();
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || clearing !== 1'b0 || disp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got hr=%b cl=%b dv=%b, want 1 0 0", host_ready, clearing, disp_valid);
    end
  endtask

  task automatic test_write_read();
    to_drive(); host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd10; host_wdata = 6'd5;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || ram_en !== 1'b0) begin
      errors++; $display("FAIL wr_accept: got hr=%b en=%b, want 1 0", host_ready, ram_en);
    end
    to_drive(); host_we = 1'b0; host_wdata = '0;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'd10, 6'd5}) begin
      errors++;
      $display("FAIL wr_issue: got en=%b we=%b a=%0d d=%0d, want 1 1 10 5", ram_en, ram_we, ram_addr, ram_wdata);
    end
    to_drive(); host_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {2'b10, 12'd10}) begin
      errors++; $display("FAIL rd_issue: got en=%b we=%b a=%0d, want 1 0 10", ram_en, ram_we, ram_addr);
    end
    to_drive();
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd5) begin
      errors++; $display("FAIL rd_data: got rv=%b d=%0d, want 1 5", host_rvalid, host_rdata);
    end
    to_drive();
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b0 || host_rdata !== 6'd5 || ram_en !== 1'b0) begin
      errors++; $display("FAIL rd_hold: got rv=%b d=%0d en=%b, want 0 5 0", host_rvalid, host_rdata, ram_en);
    end
    ref_mem[10] = 6'd5;
  endtask

  task automatic test_disp_block();
    logic       hwe [3] = '{1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ha [3] = '{12'd20, 12'd20, 12'd21};
    logic [DW-1:0] hd [3] = '{6'd7, 6'd0, 6'd9};
    int acc = 0;
    logic [DW-1:0] exp_d = '0;
    for (int k = 0; k < 5; k++) begin
      to_drive();
      disp_req = 1'b1; disp_addr = 12'(1200 + k);
      host_valid = 1'b1; host_we = hwe[acc]; host_addr = ha[acc]; host_wdata = hd[acc];
      @(negedge clk);
      checks++;
      if ({ram_en, ram_we, ram_addr} !== {2'b10, 12'(1200 + k)}) begin
        errors++; $display("FAIL blk_ram k=%0d: got en=%b we=%b a=%0d, want disp read %0d", k, ram_en, ram_we, ram_addr, 1200 + k);
      end
      if (k > 0) begin
        checks++;
        if (disp_valid !== 1'b1 || disp_data !== exp_d) begin
          errors++; $display("FAIL blk_disp k=%0d: got v=%b d=%0d, want 1 %0d", k, disp_valid, disp_data, exp_d);
        end
      end
      exp_d = ref_mem[1200 + k];
      checks++;
      if (host_ready !== (acc < 2)) begin
        errors++; $display("FAIL blk_ready k=%0d: got %b, want %b", k, host_ready, acc < 2);
      end
      if (host_ready === 1'b1) acc++;
    end
    to_drive(); disp_req = 1'b0;
    host_we = hwe[2]; host_addr = ha[2]; host_wdata = hd[2];
    @(negedge clk);
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== exp_d || host_ready !== 1'b0 ||
        {ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'd20, 6'd7}) begin
      errors++;
      $display("FAIL blk_drain1: got dv=%b dd=%0d hr=%b en=%b we=%b a=%0d d=%0d, want 1 %0d 0 1 1 20 7",
               disp_valid, disp_data, host_ready, ram_en, ram_we, ram_addr, ram_wdata, exp_d);
    end
    to_drive();
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || {ram_en, ram_we, ram_addr} !== {2'b10, 12'd20}) begin
      errors++; $display("FAIL blk_drain2: got hr=%b en=%b we=%b a=%0d, want 1 1 0 20", host_ready, ram_en, ram_we, ram_addr);
    end
    to_drive(); host_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd7 || disp_valid !== 1'b0 ||
        {ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'd21, 6'd9}) begin
      errors++;
      $display("FAIL blk_drain3: got rv=%b rd=%0d dv=%b en=%b we=%b a=%0d d=%0d, want 1 7 0 1 1 21 9",
               host_rvalid, host_rdata, disp_valid, ram_en, ram_we, ram_addr, ram_wdata);
    end
    ref_mem[20] = 6'd7; ref_mem[21] = 6'd9;
  endtask

  task automatic test_clear();
    int wr = 0;
    bit done = 0;
    to_drive(); drive_idle(); clr_screen = 1'b1;
    host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd30; host_wdata = 6'd11;
    @(negedge clk);
    checks++;
    if (clearing !== 1'b0 || host_ready !== 1'b1) begin
      errors++; $display("FAIL clr_start: got cl=%b hr=%b, want 0 1", clearing, host_ready);
    end
    for (int n = 0; n < DEPTH + 8 && !done; n++) begin
      to_drive(); drive_idle();
      @(negedge clk);
      checks++;
      if (wr < DEPTH) begin
        if (clearing !== 1'b1 || host_ready !== 1'b0 || clear_done !== 1'b0 ||
            {ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'(wr), 6'h3F}) begin
          errors++;
          $display("FAIL clr_write n=%0d: got cl=%b hr=%b cd=%b en=%b we=%b a=%0d d=%0h, want 1 0 0 1 1 %0d 3f",
                   n, clearing, host_ready, clear_done, ram_en, ram_we, ram_addr, ram_wdata, wr);
        end
        wr++;
      end else begin
        if (clearing !== 1'b0 || clear_done !== 1'b1 ||
            {ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'd30, 6'd11}) begin
          errors++;
          $display("FAIL clr_end: got cl=%b cd=%b en=%b we=%b a=%0d d=%0d, want 0 1 1 1 30 11",
                   clearing, clear_done, ram_en, ram_we, ram_addr, ram_wdata);
        end
        done = 1;
      end
    end
    to_drive();
    @(negedge clk);
    checks++;
    if (clear_done !== 1'b0 || clearing !== 1'b0 || host_ready !== 1'b1) begin
      errors++; $display("FAIL clr_after: got cd=%b cl=%b hr=%b, want 0 0 1", clear_done, clearing, host_ready);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 6'h3F;
    ref_mem[30] = 6'd11;
  endtask

  task automatic test_oor();
    to_drive(); host_valid = 1'b1; host_we = 1'b1; host_addr = 12'd2400; host_wdata = 6'd1;
    @(negedge clk);
    to_drive(); host_we = 1'b0; host_wdata = '0;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0) begin errors++; $display("FAIL oor_write: got en=%b, want 0", ram_en); end
    to_drive(); host_valid = 1'b0; disp_req = 1'b1; disp_addr = 12'd4095;
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0) begin errors++; $display("FAIL oor_disp_ram: got en=%b, want 0", ram_en); end
    to_drive(); disp_req = 1'b0; disp_addr = '0;
    @(negedge clk);
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== 6'd0 || ram_en !== 1'b0) begin
      errors++; $display("FAIL oor_disp: got v=%b d=%0d en=%b, want 1 0 0", disp_valid, disp_data, ram_en);
    end
    to_drive();
    @(negedge clk);
    checks++;
    if (host_rvalid !== 1'b1 || host_rdata !== 6'd0 || disp_valid !== 1'b0) begin
      errors++; $display("FAIL oor_host: got rv=%b d=%0d dv=%b, want 1 0 0", host_rvalid, host_rdata, disp_valid);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] hq[$];
    logic [DW-1:0] e;
    logic          dp = 1'b0;
    logic [DW-1:0] dexp = '0;
    for (int i = 0; i < 420; i++) begin
      to_drive();
      if (i < 400) begin
        disp_req   = ($urandom_range(0, 9) < 3);
        disp_addr  = 12'($urandom_range(1200, 2599));
        host_valid = ($urandom_range(0, 9) < 6);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = ($urandom_range(0, 9) == 0) ? 12'($urandom_range(2400, 2500)) : 12'($urandom_range(0, 1199));
        host_wdata = 6'($urandom_range(0, 35));
      end else drive_idle();
      @(negedge clk);
      checks++;
      if (disp_valid !== dp || (dp && disp_data !== dexp)) begin
        errors++; $display("FAIL rnd_disp i=%0d: got v=%b d=%0d, want %b %0d", i, disp_valid, disp_data, dp, dexp);
      end
      dp   = disp_req;
      dexp = (int'(disp_addr) < DEPTH) ? ref_mem[disp_addr] : '0;
      if (host_rvalid === 1'b1) begin
        checks++;
        if (hq.size() == 0) begin
          errors++; $display("FAIL rnd_host i=%0d: got unexpected rvalid d=%0d, want none", i, host_rdata);
        end else begin
          e = hq.pop_front();
          if (host_rdata !== e) begin
            errors++; $display("FAIL rnd_host i=%0d: got %0d, want %0d", i, host_rdata, e);
          end
        end
      end
      if (host_valid && host_ready === 1'b1) begin
        if (host_we) begin
          if (int'(host_addr) < DEPTH) ref_mem[host_addr] = host_wdata;
        end else hq.push_back((int'(host_addr) < DEPTH) ? ref_mem[host_addr] : '0);
      end
    end
    checks++;
    if (hq.size() != 0) begin
      errors++; $display("FAIL rnd_drain: got %0d reads outstanding, want 0", hq.size());
    end
  endtask

  task automatic test_clear_disp();
    int wr = 0, nd = 0, ncl = 0;
    bit done = 0, sawdone = 0;
    logic dp = 1'b0;
    logic [DW-1:0] dexp = '0;
    to_drive(); drive_idle(); clr_screen = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 2 * DEPTH && !done; n++) begin
      to_drive(); clr_screen = 1'b0;
      disp_req  = (n % 4 == 3);
      disp_addr = 12'($urandom_range(0, DEPTH - 1));
      @(negedge clk);
      checks++;
      if (disp_valid !== dp || (dp && disp_data !== dexp)) begin
        errors++; $display("FAIL cd_disp n=%0d: got v=%b d=%0d, want %b %0d", n, disp_valid, disp_data, dp, dexp);
      end
      dp = disp_req;
      if (disp_req) dexp = (int'(disp_addr) < wr) ? 6'h3F : ref_mem[disp_addr];
      if (clearing === 1'b1) begin
        ncl++;
        checks++;
        if (disp_req) begin
          if ({ram_en, ram_we, ram_addr} !== {2'b10, disp_addr}) begin
            errors++; $display("FAIL cd_rd n=%0d: got en=%b we=%b a=%0d, want 1 0 %0d", n, ram_en, ram_we, ram_addr, disp_addr);
          end
          nd++;
        end else begin
          if ({ram_en, ram_we, ram_addr, ram_wdata} !== {2'b11, 12'(wr), 6'h3F}) begin
            errors++; $display("FAIL cd_wr n=%0d: got en=%b we=%b a=%0d, want 1 1 %0d", n, ram_en, ram_we, ram_addr, wr);
          end
          wr++;
        end
      end else begin
        done = 1;
        sawdone = (clear_done === 1'b1);
      end
    end
    to_drive(); drive_idle();
    @(negedge clk);
    checks++;
    if (disp_valid !== dp || (dp && disp_data !== dexp)) begin
      errors++; $display("FAIL cd_disp_last: got v=%b d=%0d, want %b %0d", disp_valid, disp_data, dp, dexp);
    end
    checks++;
    if (!done || !sawdone || wr != DEPTH || ncl != DEPTH + nd) begin
      errors++;
      $display("FAIL cd_duration: got cycles=%0d writes=%0d done=%0d, want cycles=%0d writes=%0d done=1",
               ncl, wr, sawdone, DEPTH + nd, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 6'h3F;
  endtask

  task automatic test_reset_mid_clear();
    bit hit = 0;
    to_drive(); drive_idle(); clr_screen = 1'b1;
    @(negedge clk);
    for (int n = 0; n < 1500 && !hit; n++) begin
      to_drive(); clr_screen = 1'b0;
      @(negedge clk);
      if (ram_en === 1'b1 && ram_we === 1'b1 && ram_addr === 12'd1000) hit = 1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rmc_reach: got no write to 1000, want one"); end
    #1 clr_n = 1'b0;
    #1;
    checks++;
    if ({disp_valid, disp_data, host_ready, host_rvalid, host_rdata, clearing, clear_done,
         ram_en, ram_we, ram_addr, ram_wdata} !== 37'd0) begin
      errors++;
      $display("FAIL rmc_zero: got cl=%b en=%b we=%b a=%0d hr=%b, want all 0", clearing, ram_en, ram_we, ram_addr, host_ready);
    end
    @(negedge clk); @(negedge clk); clr_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      to_drive();
      @(negedge clk);
      checks++;
      if (clearing !== 1'b0 || clear_done !== 1'b0 || ram_en !== 1'b0 || host_ready !== 1'b1) begin
        errors++;
        $display("FAIL rmc_idle n=%0d: got cl=%b cd=%b en=%b hr=%b, want 0 0 0 1", n, clearing, clear_done, ram_en, host_ready);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 6'((i * 7) % 36);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 6'((i * 7) % 36);
    test_reset();
    test_write_read();
    test_disp_block();
    test_clear();
    test_oor();
    test_random();
    test_clear_disp();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
